// File: rtl/ready_table_wport_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ready_table_wport_pkg : shared types for the ready-table write port |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package ready_table_wport_pkg;

   localparam int PREG_W   = 6;
   localparam int NUM_PREG = 1 << PREG_W;

   typedef struct packed {
      logic [PREG_W-1:0] preg;
      logic              data;
   } ready_wr_t;

   // Push order within one cycle; alloc is always the youngest slot.
   typedef enum logic [1:0] {
      SLOT_WB0   = 2'd0,
      SLOT_WB1   = 2'd1,
      SLOT_ALLOC = 2'd2
   } wr_slot_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rt_state_e;

endpackage
`default_nettype wire

// File: rtl/rt_pending_q.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rt_pending_q : multi-push, single-pop FIFO of pending ready writes  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rt_pending_q
   import ready_table_wport_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int NPUSH = 3
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NPUSH-1:0]       i_push,
   input  ready_wr_t              i_push_data [NPUSH],
   input  logic                   i_pop,
   output ready_wr_t              o_head,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count,
   output ready_wr_t              o_ent [DEPTH],
   output logic [DEPTH-1:0]       o_ent_vld
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ready_wr_t         r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;

   logic [AW-1:0]     w_slot [NPUSH];
   logic [CW-1:0]     w_npush;
   logic              w_pop;

   // Valid pushes are packed densely behind the write pointer in slot order.
   always_comb begin
      w_npush = '0;
      for (int k = 0; k < NPUSH; k++) begin
         w_slot[k] = r_wr_ptr + w_npush[AW-1:0];
         w_npush   = w_npush + CW'(i_push[k]);
      end
   end

   assign w_pop = i_pop && (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_wr_ptr <= r_wr_ptr + w_npush[AW-1:0];
         r_count  <= r_count + w_npush - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NPUSH; k++) begin
         if (i_push[k]) begin
            r_mem[w_slot[k]] <= i_push_data[k];
         end
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   // Entries are presented oldest-first so a higher index is a younger write.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
         assign o_ent[i]     = r_mem[r_rd_ptr + AW'(i)];
         assign o_ent_vld[i] = (CW'(i) < r_count);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ready_table_wport.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ready_table_wport : write scheduler / read correction, ready table  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ready_table_wport #(
   parameter int WB_PORTS = 2,
   parameter int RD_PORTS = 3,
   parameter int QDEPTH   = 8,
   parameter int PREG_W   = 6
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         alloc_valid,
   input  logic [PREG_W-1:0]            alloc_preg,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*PREG_W-1:0]   wb_preg,
   input  logic [RD_PORTS*PREG_W-1:0]   rd_preg,
   output logic [RD_PORTS-1:0]          rd_ready,
   output logic                         stall,
   output logic                         init_done,
   output logic [RD_PORTS*PREG_W-1:0]   ram_a,
   input  logic [RD_PORTS-1:0]          ram_q,
   output logic                         ram_we,
   output logic [PREG_W-1:0]            ram_aw,
   output logic                         ram_di
);

   import ready_table_wport_pkg::*;

   localparam int NPUSH      = WB_PORTS + 1;
   localparam int ALLOC_SLOT = WB_PORTS;
   localparam int CW         = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] STALL_THR = CW'(QDEPTH - NPUSH);

   rt_state_e           r_state;
   rt_state_e           w_state_nxt;
   logic                r_sweep_en;
   logic [PREG_W-1:0]   r_cnt;
   logic [PREG_W-1:0]   w_cnt_nxt;

   ready_wr_t           w_push_data [NPUSH];
   logic [NPUSH-1:0]    w_push;
   logic                w_accept;
   logic                w_pop;

   ready_wr_t           w_q_head;
   logic                w_q_empty;
   logic [CW-1:0]       w_q_count;
   ready_wr_t           w_ent [QDEPTH];
   logic [QDEPTH-1:0]   w_ent_vld;

   // r_sweep_en holds the sweep off until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_cnt      <= '0;
         r_sweep_en <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sweep_en <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      ram_we      = 1'b0;
      ram_aw      = w_q_head.preg;
      ram_di      = w_q_head.data;
      w_pop       = 1'b0;
      stall       = 1'b1;
      init_done   = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (r_sweep_en) begin
               ram_we    = 1'b1;
               ram_aw    = r_cnt;
               ram_di    = 1'b1;
               w_cnt_nxt = r_cnt + PREG_W'(1);
               if (r_cnt == PREG_W'(NUM_PREG - 1)) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            init_done = 1'b1;
            stall     = (w_q_count > STALL_THR);
            w_pop     = !w_q_empty;
            ram_we    = w_pop;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   assign w_accept = (r_state == ST_RUN) && !stall;

   generate
      for (genvar k = 0; k < WB_PORTS; k++) begin : g_wb_slot
         assign w_push_data[int'(SLOT_WB0) + k] = '{preg: wb_preg[k*PREG_W +: PREG_W], data: 1'b1};
         assign w_push[int'(SLOT_WB0) + k]      = w_accept && wb_valid[k] &&
                                                  (wb_preg[k*PREG_W +: PREG_W] != '0);
      end
   endgenerate

   assign w_push_data[ALLOC_SLOT] = '{preg: alloc_preg, data: 1'b0};
   assign w_push[ALLOC_SLOT]      = w_accept && alloc_valid && (alloc_preg != '0);

   rt_pending_q #(
      .DEPTH (QDEPTH),
      .NPUSH (NPUSH)
   ) u_pending_q (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_q_head),
      .o_empty     (w_q_empty),
      .o_count     (w_q_count),
      .o_ent       (w_ent),
      .o_ent_vld   (w_ent_vld)
   );

   assign ram_a = rd_preg;

   // The last matching entry in age order is the youngest write and wins.
   always_comb begin
      rd_ready = ram_q;
      if (r_state == ST_RUN) begin
         for (int r = 0; r < RD_PORTS; r++) begin
            for (int i = 0; i < QDEPTH; i++) begin
               if (w_ent_vld[i] && (w_ent[i].preg == rd_preg[r*PREG_W +: PREG_W])) begin
                  rd_ready[r] = w_ent[i].data;
               end
            end
            if (rd_preg[r*PREG_W +: PREG_W] == '0) begin
               rd_ready[r] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_sweep_en) begin
         assert (!(stall && (alloc_valid || (|wb_valid))));
      end
   end

   generate
      for (genvar k = 0; k < WB_PORTS; k++) begin : g_same_preg_chk
         always_ff @(posedge clk) begin
            if (r_sweep_en) begin
               assert (!(w_accept && alloc_valid && wb_valid[k] && (alloc_preg != '0) &&
                         (wb_preg[k*PREG_W +: PREG_W] == alloc_preg)));
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire
